// File: rtl/irq_dispatch_pkg.sv
// rtl/irq_dispatch_pkg.sv - shared types and resolver decode for the interrupt dispatcher
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PRESENT,
    ST_CLEAR,
    ST_COOL
  } irq_state_t;

  localparam logic [1:0] GRP_NONE = 2'd0;
  localparam logic [1:0] GRP_A    = 2'd1;
  localparam logic [1:0] GRP_B    = 2'd2;
  localparam logic [1:0] GRP_C    = 2'd3;

  typedef struct packed {
    logic [1:0] grp;
    logic [3:0] chan;
  } irq_vec_t;

  // Group A outranks B outranks C; a "none" sample carries a zero channel.
  function automatic irq_vec_t decode_sample(input logic a, input logic b, input logic c,
                                             input logic [3:0] ch);
    irq_vec_t v;
    v.chan = ch;
    if (a)      v.grp = GRP_A;
    else if (b) v.grp = GRP_B;
    else if (c) v.grp = GRP_C;
    else begin
      v.grp  = GRP_NONE;
      v.chan = 4'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_dispatch_if.sv
// rtl/irq_dispatch_if.sv - resolver, CPU and clear-source signals of the dispatcher
interface irq_dispatch_if;
  logic       grp_a;
  logic       grp_b;
  logic       grp_c;
  logic [3:0] chan;
  logic       irq_valid;
  logic [5:0] irq_vec;
  logic       irq_ack;
  logic       clr_valid;
  logic [1:0] clr_grp;
  logic [3:0] clr_chan;
  logic       clr_ready;
  logic       timeout_err;

  modport master (
    input  grp_a, grp_b, grp_c, chan, irq_ack, clr_ready,
    output irq_valid, irq_vec, clr_valid, clr_grp, clr_chan, timeout_err
  );

  modport slave (
    output grp_a, grp_b, grp_c, chan, irq_ack, clr_ready,
    input  irq_valid, irq_vec, clr_valid, clr_grp, clr_chan, timeout_err
  );
endinterface

// File: rtl/irq_dispatch_settle.sv
// rtl/irq_dispatch_settle.sv - snapshot register and stability counter for resolver samples
module irq_settle
  import irq_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_en,
  input  logic     i_first,
  input  irq_vec_t i_sample,
  output logic     o_stable,
  output irq_vec_t o_snap
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] r_cnt;
  irq_vec_t      r_snap;
  logic          w_none;
  logic          w_match;

  assign w_none  = (i_sample.grp == GRP_NONE);
  assign w_match = !i_first && (i_sample == r_snap);

  // In IDLE the fresh sample counts as the first stable one, so SETTLE=1 dispatches immediately.
  assign o_stable = !w_none &&
                    ((i_first && (SETTLE == 1)) ||
                     (w_match && ((32'(r_cnt) + 32'd1) == 32'(SETTLE))));
  assign o_snap   = r_snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else if (i_en && !w_none) begin
      if (!w_match) begin
        r_snap <= i_sample;
        r_cnt  <= CW'(1);
      end else if (r_cnt != CW'(SETTLE)) begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// rtl/irq_dispatch.sv - settles resolver output, presents one vector, then clears the source
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int SETTLE      = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int HOLDOFF     = 2
) (
  input logic          clk,
  input logic          rst,
  irq_dispatch_if.master bus
);

  localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  irq_state_t    r_state;
  irq_state_t    w_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [HO_W-1:0] r_ho_cnt;
  logic          r_irq_valid;
  irq_vec_t      r_irq_vec;
  logic          r_clr_valid;
  logic [1:0]    r_clr_grp;
  logic [3:0]    r_clr_chan;
  logic          r_timeout_err;

  irq_vec_t      w_sample;
  irq_vec_t      w_snap;
  logic          w_stable;
  logic          w_to_fire;

  assign w_sample = decode_sample(bus.grp_a, bus.grp_b, bus.grp_c, bus.chan);

  irq_settle #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .i_en     ((r_state == ST_IDLE) || (r_state == ST_SETTLE)),
    .i_first  (r_state == ST_IDLE),
    .i_sample (w_sample),
    .o_stable (w_stable),
    .o_snap   (w_snap)
  );

  always_comb begin
    w_next    = r_state;
    w_to_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sample.grp != GRP_NONE) w_next = w_stable ? ST_PRESENT : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_sample.grp == GRP_NONE) w_next = ST_IDLE;
        else if (w_stable)            w_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Ack takes precedence over a timeout expiring in the same cycle.
        if (bus.irq_ack) begin
          w_next = ST_CLEAR;
        end else if ((ACK_TIMEOUT != 0) && (r_to_cnt == TO_W'(ACK_TIMEOUT - 1))) begin
          w_next    = ST_IDLE;
          w_to_fire = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (bus.clr_ready) w_next = (HOLDOFF > 0) ? ST_COOL : ST_IDLE;
      end
      ST_COOL: begin
        if (r_ho_cnt == HO_W'(HOLDOFF - 1)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_to_cnt      <= '0;
      r_ho_cnt      <= '0;
      r_irq_valid   <= 1'b0;
      r_irq_vec     <= '0;
      r_clr_valid   <= 1'b0;
      r_clr_grp     <= '0;
      r_clr_chan    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;

      if ((r_state == ST_PRESENT) && (w_next == ST_PRESENT)) begin
        if (r_to_cnt != TO_W'(ACK_TIMEOUT)) r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end

      if ((r_state == ST_COOL) && (w_next == ST_COOL)) begin
        if (r_ho_cnt != HO_W'(HOLDOFF)) r_ho_cnt <= r_ho_cnt + HO_W'(1);
      end else begin
        r_ho_cnt <= '0;
      end

      r_irq_valid <= (w_next == ST_PRESENT);
      if (w_next == ST_PRESENT)
        r_irq_vec <= (r_state == ST_PRESENT) ? r_irq_vec : w_sample;
      else
        r_irq_vec <= '0;

      r_clr_valid <= (w_next == ST_CLEAR);
      r_clr_grp   <= (w_next == ST_CLEAR) ? w_snap.grp  : 2'd0;
      r_clr_chan  <= (w_next == ST_CLEAR) ? w_snap.chan : 4'd0;

      if (w_to_fire) r_timeout_err <= 1'b1;
    end
  end

  assign bus.irq_valid   = r_irq_valid;
  assign bus.irq_vec     = r_irq_vec;
  assign bus.clr_valid   = r_clr_valid;
  assign bus.clr_grp     = r_clr_grp;
  assign bus.clr_chan    = r_clr_chan;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_irq_dispatch.sv
// tb/tb_irq_dispatch.sv - scoreboard bench for irq_dispatch with default and short-timeout instances
module tb_irq_dispatch;

  typedef struct {
    logic [5:0] vec;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_v0 = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  irq_dispatch_if if0();
  irq_dispatch_if if1();

  irq_dispatch dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (if0.master)
  );

  irq_dispatch #(.SETTLE(2), .ACK_TIMEOUT(4), .HOLDOFF(2)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1.master)
  );

  // Every irq_valid rising edge on dut0 must match the next queued vector and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (if0.irq_valid && !prev_v0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: dispatch vec=%h at cycle %0d, required none", if0.irq_vec, cyc);
      end else begin
        e = sb.pop_front();
        if (if0.irq_vec !== e.vec || cyc != e.cyc) begin
          n_errors++;
          $display("FAIL sb_dispatch: vec=%h cycle=%0d, required vec=%h cycle=%0d",
                   if0.irq_vec, cyc, e.vec, e.cyc);
        end
      end
    end
    prev_v0 = if0.irq_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_inputs0();
    if0.grp_a = 1'b0;
    if0.grp_b = 1'b0;
    if0.grp_c = 1'b0;
    if0.chan  = 4'd0;
  endtask

  // Called in the first PRESENT cycle; returns with dut0 back in IDLE.
  task automatic do_ack_clear0();
    if0.irq_ack = 1'b1;
    drop_inputs0();
    step();
    if0.irq_ack   = 1'b0;
    if0.clr_ready = 1'b1;
    step();
    if0.clr_ready = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) step();
    n_checks++;
    if ({if0.irq_valid, if0.irq_vec, if0.clr_valid, if0.clr_grp, if0.clr_chan, if0.timeout_err} !== 15'h0) begin
      n_errors++;
      $display("FAIL reset_dut0: outputs=%h, required 0",
               {if0.irq_valid, if0.irq_vec, if0.clr_valid, if0.clr_grp, if0.clr_chan, if0.timeout_err});
    end
    n_checks++;
    if ({if1.irq_valid, if1.irq_vec, if1.clr_valid, if1.clr_grp, if1.clr_chan, if1.timeout_err} !== 15'h0) begin
      n_errors++;
      $display("FAIL reset_dut1: outputs=%h, required 0",
               {if1.irq_valid, if1.irq_vec, if1.clr_valid, if1.clr_grp, if1.clr_chan, if1.timeout_err});
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int c0 = cyc;
    if0.grp_b = 1'b1;
    if0.chan  = 4'd5;
    sb.push_back('{6'h25, c0 + 2});
    repeat (2) step();
    n_checks++;
    if (if0.irq_valid !== 1'b1 || if0.irq_vec !== 6'h25) begin
      n_errors++;
      $display("FAIL basic_present: valid=%b vec=%h, required 1/25", if0.irq_valid, if0.irq_vec);
    end
    repeat (2) step();
    if0.irq_ack = 1'b1;
    step();
    n_checks++;
    if (if0.clr_valid !== 1'b1 || if0.clr_grp !== 2'd2 || if0.clr_chan !== 4'd5 || if0.irq_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_clear: clr_valid=%b grp=%0d chan=%0d irq_valid=%b, required 1/2/5/0",
               if0.clr_valid, if0.clr_grp, if0.clr_chan, if0.irq_valid);
    end
    if0.irq_ack   = 1'b0;
    if0.clr_ready = 1'b1;
    drop_inputs0();
    step();
    n_checks++;
    if (if0.clr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_clr_drop: clr_valid=%b, required 0", if0.clr_valid);
    end
    if0.clr_ready = 1'b0;
    if0.irq_ack   = 1'b1;
    repeat (4) step();
    if0.irq_ack = 1'b0;
    n_checks++;
    if (if0.irq_valid !== 1'b0 || if0.clr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_idle: irq_valid=%b clr_valid=%b, required 0/0", if0.irq_valid, if0.clr_valid);
    end
  endtask

  task automatic test_glitch();
    int c0 = cyc;
    if0.grp_a = 1'b1;
    if0.chan  = 4'd3;
    step();
    if0.chan = 4'd4;
    sb.push_back('{6'h14, c0 + 3});
    repeat (2) step();
    n_checks++;
    if (if0.irq_valid !== 1'b1 || if0.irq_vec !== 6'h14) begin
      n_errors++;
      $display("FAIL glitch_vec: valid=%b vec=%h, required 1/14", if0.irq_valid, if0.irq_vec);
    end
    do_ack_clear0();
    if0.grp_a = 1'b1;
    if0.chan  = 4'd6;
    step();
    drop_inputs0();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (if0.irq_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL glitch_drop: irq_valid=%b at step %0d, required 0", if0.irq_valid, i);
      end
    end
  endtask

  task automatic test_simul();
    int c0 = cyc;
    if0.grp_a = 1'b1;
    if0.grp_c = 1'b1;
    if0.chan  = 4'd7;
    sb.push_back('{6'h17, c0 + 2});
    repeat (2) step();
    n_checks++;
    if (if0.irq_vec !== 6'h17) begin
      n_errors++;
      $display("FAIL simul_prio: vec=%h, required 17", if0.irq_vec);
    end
    do_ack_clear0();
  endtask

  task automatic test_stale();
    int c0 = cyc;
    if0.grp_c = 1'b1;
    if0.chan  = 4'd9;
    sb.push_back('{6'h39, c0 + 2});
    repeat (2) step();
    if0.irq_ack = 1'b1;
    step();
    if0.irq_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (if0.clr_valid !== 1'b1 || if0.clr_grp !== 2'd3 || if0.clr_chan !== 4'd9) begin
        n_errors++;
        $display("FAIL stale_hold: clr_valid=%b grp=%0d chan=%0d at step %0d, required 1/3/9",
                 if0.clr_valid, if0.clr_grp, if0.clr_chan, i);
      end
      if (i == 5) begin
        if0.clr_ready = 1'b1;
        sb.push_back('{6'h39, cyc + 1 + 2 + 2});
      end
      step();
    end
    if0.clr_ready = 1'b0;
    n_checks++;
    if (if0.clr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stale_clr_drop: clr_valid=%b, required 0", if0.clr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (if0.irq_valid !== (i == 3)) begin
        n_errors++;
        $display("FAIL stale_redispatch: irq_valid=%b at step %0d, required %b", if0.irq_valid, i, (i == 3));
      end
    end
    do_ack_clear0();
  endtask

  task automatic test_rst_mid();
    int c0 = cyc;
    if0.grp_a = 1'b1;
    if0.chan  = 4'd2;
    sb.push_back('{6'h12, c0 + 2});
    repeat (2) step();
    rst0 = 1'b1;
    step();
    n_checks++;
    if ({if0.irq_valid, if0.irq_vec, if0.clr_valid, if0.clr_grp, if0.clr_chan, if0.timeout_err} !== 15'h0) begin
      n_errors++;
      $display("FAIL rst_present: outputs=%h, required 0",
               {if0.irq_valid, if0.irq_vec, if0.clr_valid, if0.clr_grp, if0.clr_chan, if0.timeout_err});
    end
    rst0 = 1'b0;
    sb.push_back('{6'h12, cyc + 2});
    repeat (2) step();
    if0.irq_ack = 1'b1;
    step();
    if0.irq_ack = 1'b0;
    n_checks++;
    if (if0.clr_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_reach_clear: clr_valid=%b, required 1", if0.clr_valid);
    end
    rst0 = 1'b1;
    step();
    n_checks++;
    if ({if0.irq_valid, if0.irq_vec, if0.clr_valid, if0.clr_grp, if0.clr_chan, if0.timeout_err} !== 15'h0) begin
      n_errors++;
      $display("FAIL rst_clear: outputs=%h, required 0",
               {if0.irq_valid, if0.irq_vec, if0.clr_valid, if0.clr_grp, if0.clr_chan, if0.timeout_err});
    end
    rst0 = 1'b0;
    sb.push_back('{6'h12, cyc + 2});
    repeat (2) step();
    n_checks++;
    if (if0.irq_valid !== 1'b1 || if0.irq_vec !== 6'h12) begin
      n_errors++;
      $display("FAIL rst_fresh: valid=%b vec=%h, required 1/12", if0.irq_valid, if0.irq_vec);
    end
    do_ack_clear0();
  endtask

  task automatic test_timeout();
    if1.grp_b = 1'b1;
    if1.chan  = 4'd1;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (if1.irq_valid !== 1'b1 || if1.irq_vec !== 6'h21 || if1.timeout_err !== 1'b0) begin
        n_errors++;
        $display("FAIL to_present: valid=%b vec=%h err=%b at step %0d, required 1/21/0",
                 if1.irq_valid, if1.irq_vec, if1.timeout_err, i);
      end
      if (i == 0) if1.grp_b = 1'b0;
      step();
    end
    n_checks++;
    if (if1.irq_valid !== 1'b0 || if1.timeout_err !== 1'b1 || if1.clr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL to_fire: valid=%b err=%b clr_valid=%b, required 0/1/0",
               if1.irq_valid, if1.timeout_err, if1.clr_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (if1.clr_valid !== 1'b0 || if1.timeout_err !== 1'b1) begin
        n_errors++;
        $display("FAIL to_sticky: clr_valid=%b err=%b at step %0d, required 0/1",
                 if1.clr_valid, if1.timeout_err, i);
      end
    end
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    n_checks++;
    if (if1.timeout_err !== 1'b0 || if1.irq_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL to_rst: err=%b valid=%b, required 0/0", if1.timeout_err, if1.irq_valid);
    end
    if1.grp_b = 1'b1;
    if1.chan  = 4'd1;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) if1.grp_b = 1'b0;
      if (i == 3) if1.irq_ack = 1'b1;
      step();
    end
    if1.irq_ack = 1'b0;
    n_checks++;
    if (if1.clr_valid !== 1'b1 || if1.timeout_err !== 1'b0 || if1.clr_grp !== 2'd2 || if1.clr_chan !== 4'd1) begin
      n_errors++;
      $display("FAIL to_ack_wins: clr_valid=%b err=%b grp=%0d chan=%0d, required 1/0/2/1",
               if1.clr_valid, if1.timeout_err, if1.clr_grp, if1.clr_chan);
    end
    if1.clr_ready = 1'b1;
    step();
    if1.clr_ready = 1'b0;
    n_checks++;
    if (if1.clr_valid !== 1'b0 || if1.timeout_err !== 1'b0) begin
      n_errors++;
      $display("FAIL to_after_clear: clr_valid=%b err=%b, required 0/0", if1.clr_valid, if1.timeout_err);
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.grp_a = 1'b0; if0.grp_b = 1'b0; if0.grp_c = 1'b0; if0.chan = 4'd0;
    if0.irq_ack = 1'b0; if0.clr_ready = 1'b0;
    if1.grp_a = 1'b0; if1.grp_b = 1'b0; if1.grp_c = 1'b0; if1.chan = 4'd0;
    if1.irq_ack = 1'b0; if1.clr_ready = 1'b0;

    test_reset();
    test_basic();
    test_glitch();
    test_simul();
    test_stale();
    test_rst_mid();
    test_timeout();
    repeat (3) step();

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d dispatches outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
